// File: rtl/creek_imem_ctrl.sv
// Multi-bank instruction memory for the creek vector core, with the run-control
// sequencer that parks the core before any change to the bank it fetches from.
//
// state  | meaning
// IDLE   | core parked, waiting for go/swap
// SWAP   | switch active bank to the latched target
// RESUME | one-cycle resume pulse to the core
// RUN    | core executing, watching for completion
// DRAIN  | pause requested, waiting for core to park
module creek_imem_ctrl #(
  parameter int INSTR_WIDTH = 16,
  parameter int ADDR_WIDTH  = 10,
  parameter int NUM_BANKS   = 2,
  parameter int CNT_WIDTH   = 16,
  localparam int BANK_BITS  = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [ADDR_WIDTH-1:0]  host_addr,
  input  logic [BANK_BITS-1:0]   host_bank,
  input  logic [INSTR_WIDTH-1:0] host_wdata,
  input  logic                   host_write,
  output logic                   host_waitrequest,
  input  logic                   ctrl_go,
  input  logic                   ctrl_swap,
  input  logic [BANK_BITS-1:0]   ctrl_bank,
  input  logic                   ctrl_halt,
  output logic                   ctrl_ready,
  output logic [BANK_BITS-1:0]   status_active_bank,
  output logic                   status_running,
  output logic [CNT_WIDTH-1:0]   status_run_count,
  input  logic [ADDR_WIDTH-1:0]  core_instr_address,
  output logic [INSTR_WIDTH-1:0] core_instr_data,
  output logic                   core_pause_n,
  output logic                   core_resume,
  input  logic                   core_waiting
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] SWAP   = 3'd1;
  localparam logic [2:0] RESUME = 3'd2;
  localparam logic [2:0] RUN    = 3'd3;
  localparam logic [2:0] DRAIN  = 3'd4;

  logic [2:0]             state;
  logic [BANK_BITS-1:0]   active_bank;
  logic [BANK_BITS-1:0]   pending_bank;
  logic                   pending_swap;
  logic                   seen_busy;
  logic [CNT_WIDTH-1:0]   run_count;
  logic                   run_done;
  logic                   wr_en;
  logic [INSTR_WIDTH-1:0] mem [NUM_BANKS][DEPTH];

  assign ctrl_ready         = (state == IDLE) || (state == RUN);
  assign core_pause_n       = (state == RESUME) || (state == RUN);
  assign core_resume        = (state == RESUME);
  assign status_running     = (state == RUN);
  assign status_active_bank = active_bank;
  assign status_run_count   = run_count;

  // Writing the bank the core fetches from is only safe once the core is parked.
  assign host_waitrequest = host_write && (host_bank == active_bank) && (state != IDLE);
  assign wr_en = host_write && !host_waitrequest && (32'(host_bank) < NUM_BANKS);

  assign run_done = seen_busy && core_waiting;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      active_bank  <= '0;
      pending_bank <= '0;
      pending_swap <= 1'b0;
      seen_busy    <= 1'b0;
      run_count    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (ctrl_halt) begin
            state <= IDLE;
          end else if (ctrl_swap) begin
            pending_bank <= ctrl_bank;
            state        <= SWAP;
          end else if (ctrl_go) begin
            state <= RESUME;
          end
        end
        SWAP: begin
          if (32'(pending_bank) < NUM_BANKS) active_bank <= pending_bank;
          pending_swap <= 1'b0;
          state        <= RESUME;
        end
        RESUME: begin
          seen_busy <= 1'b0;
          state     <= RUN;
        end
        RUN: begin
          if (!core_waiting) seen_busy <= 1'b1;
          if (run_done) run_count <= run_count + 1'b1;
          // A halt/swap in the completion cycle still counts the finished run.
          if (ctrl_halt || ctrl_swap) begin
            pending_swap <= !ctrl_halt;
            if (!ctrl_halt) pending_bank <= ctrl_bank;
            state <= DRAIN;
          end else if (run_done) begin
            state <= IDLE;
          end
        end
        DRAIN: begin
          if (core_waiting) state <= pending_swap ? SWAP : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Separate read and write ports; a same-word collision returns the old word.
  always_ff @(posedge clk) begin
    if (wr_en) mem[host_bank][host_addr] <= host_wdata;
    core_instr_data <= mem[active_bank][core_instr_address];
  end

endmodule

// File: tb/tb_creek_imem_ctrl.sv
// Directed bench for creek_imem_ctrl: a cycle table for the run-control sequence
// plus hand sequences for fetches, counter wrap and asynchronous reset.
module tb_creek_imem_ctrl;

  logic        clk;
  logic        reset_n;
  logic [9:0]  host_addr;
  logic [0:0]  host_bank;
  logic [15:0] host_wdata;
  logic        host_write;
  logic        host_waitrequest;
  logic        ctrl_go, ctrl_swap, ctrl_halt;
  logic [0:0]  ctrl_bank;
  logic        ctrl_ready;
  logic [0:0]  status_active_bank;
  logic        status_running;
  logic [15:0] status_run_count;
  logic [9:0]  core_instr_address;
  logic [15:0] core_instr_data;
  logic        core_pause_n, core_resume, core_waiting;

  logic        s_waitrequest, s_ready, s_running, s_pause_n, s_resume;
  logic [0:0]  s_active_bank;
  logic [1:0]  s_run_count;
  logic [15:0] s_instr_data;

  int n_total = 0;
  int n_pass  = 0;

  creek_imem_ctrl u_dut (
    .clk(clk), .reset_n(reset_n),
    .host_addr(host_addr), .host_bank(host_bank), .host_wdata(host_wdata),
    .host_write(host_write), .host_waitrequest(host_waitrequest),
    .ctrl_go(ctrl_go), .ctrl_swap(ctrl_swap), .ctrl_bank(ctrl_bank), .ctrl_halt(ctrl_halt),
    .ctrl_ready(ctrl_ready), .status_active_bank(status_active_bank),
    .status_running(status_running), .status_run_count(status_run_count),
    .core_instr_address(core_instr_address), .core_instr_data(core_instr_data),
    .core_pause_n(core_pause_n), .core_resume(core_resume), .core_waiting(core_waiting)
  );

  // Narrow-counter copy driven in lockstep, to reach the counter wrap quickly.
  creek_imem_ctrl #(.CNT_WIDTH(2)) u_dut_w (
    .clk(clk), .reset_n(reset_n),
    .host_addr(host_addr), .host_bank(host_bank), .host_wdata(host_wdata),
    .host_write(host_write), .host_waitrequest(s_waitrequest),
    .ctrl_go(ctrl_go), .ctrl_swap(ctrl_swap), .ctrl_bank(ctrl_bank), .ctrl_halt(ctrl_halt),
    .ctrl_ready(s_ready), .status_active_bank(s_active_bank),
    .status_running(s_running), .status_run_count(s_run_count),
    .core_instr_address(core_instr_address), .core_instr_data(s_instr_data),
    .core_pause_n(s_pause_n), .core_resume(s_resume), .core_waiting(core_waiting)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          go, swap, halt, cbank, cw, hw, hbank;
    logic [9:0]  haddr;
    logic [15:0] hdata;
    logic [21:0] exp;
  } vec_t;

  vec_t tbl[26];

  function automatic logic [21:0] ex(bit p, bit r, bit ru, bit rd, bit bk, logic [15:0] c, bit w);
    return {p, r, ru, rd, bk, c, w};
  endfunction

  function automatic vec_t mk(bit go, bit swap, bit halt, bit cb, bit cw, bit hw, bit hb,
                              logic [9:0] ha, logic [15:0] hd, logic [21:0] e);
    vec_t v;
    v.go = go; v.swap = swap; v.halt = halt; v.cbank = cb; v.cw = cw;
    v.hw = hw; v.hbank = hb; v.haddr = ha; v.hdata = hd; v.exp = e;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [21:0] obs();
    return {core_pause_n, core_resume, status_running, ctrl_ready,
            status_active_bank, status_run_count, host_waitrequest};
  endfunction

  task automatic fetch_chk(string name, logic [9:0] a, logic [15:0] exp);
    @(negedge clk);
    core_instr_address = a;
    @(posedge clk);
    #1;
    chk(name, {16'h0, core_instr_data}, {16'h0, exp});
  endtask

  task automatic run_once();
    @(negedge clk); ctrl_go = 1'b1; core_waiting = 1'b1;
    @(negedge clk); ctrl_go = 1'b0;
    @(negedge clk); core_waiting = 1'b0;
    @(negedge clk); core_waiting = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    reset_n = 1'b0;
    host_addr = '0; host_bank = '0; host_wdata = '0; host_write = 1'b0;
    ctrl_go = 1'b0; ctrl_swap = 1'b0; ctrl_halt = 1'b0; ctrl_bank = '0;
    core_instr_address = '0; core_waiting = 1'b1;

    //          go sw ht cb cw hw hb  addr     data      expected after the edge
    tbl[0]  = mk(1, 0, 0, 0, 1, 0, 0, 10'd0, 16'h0000, ex(1,1,0,0,0,16'd0,0));
    tbl[1]  = mk(0, 0, 0, 0, 1, 0, 0, 10'd0, 16'h0000, ex(1,0,1,1,0,16'd0,0));
    tbl[2]  = mk(0, 0, 0, 0, 1, 0, 0, 10'd0, 16'h0000, ex(1,0,1,1,0,16'd0,0));
    tbl[3]  = mk(0, 0, 0, 0, 0, 0, 0, 10'd0, 16'h0000, ex(1,0,1,1,0,16'd0,0));
    tbl[4]  = mk(0, 0, 0, 0, 0, 1, 1, 10'd0, 16'hBEEF, ex(1,0,1,1,0,16'd0,0));
    tbl[5]  = mk(0, 0, 0, 0, 0, 0, 0, 10'd0, 16'h0000, ex(1,0,1,1,0,16'd0,0));
    tbl[6]  = mk(0, 0, 0, 0, 1, 0, 0, 10'd0, 16'h0000, ex(0,0,0,1,0,16'd1,0));
    tbl[7]  = mk(1, 0, 0, 0, 1, 0, 0, 10'd0, 16'h0000, ex(1,1,0,0,0,16'd1,0));
    tbl[8]  = mk(0, 0, 0, 0, 1, 0, 0, 10'd0, 16'h0000, ex(1,0,1,1,0,16'd1,0));
    tbl[9]  = mk(0, 0, 0, 0, 0, 0, 0, 10'd0, 16'h0000, ex(1,0,1,1,0,16'd1,0));
    tbl[10] = mk(0, 0, 0, 0, 0, 1, 0, 10'd7, 16'h5A5A, ex(1,0,1,1,0,16'd1,1));
    tbl[11] = mk(0, 0, 1, 0, 0, 1, 0, 10'd7, 16'h5A5A, ex(0,0,0,0,0,16'd1,1));
    tbl[12] = mk(0, 0, 0, 0, 0, 1, 0, 10'd7, 16'h5A5A, ex(0,0,0,0,0,16'd1,1));
    tbl[13] = mk(0, 0, 0, 0, 1, 1, 0, 10'd7, 16'h5A5A, ex(0,0,0,1,0,16'd1,0));
    tbl[14] = mk(0, 0, 0, 0, 1, 1, 0, 10'd7, 16'h5A5A, ex(0,0,0,1,0,16'd1,0));
    tbl[15] = mk(1, 0, 0, 0, 1, 0, 0, 10'd0, 16'h0000, ex(1,1,0,0,0,16'd1,0));
    tbl[16] = mk(0, 0, 0, 0, 1, 0, 0, 10'd0, 16'h0000, ex(1,0,1,1,0,16'd1,0));
    tbl[17] = mk(0, 0, 0, 0, 0, 0, 0, 10'd0, 16'h0000, ex(1,0,1,1,0,16'd1,0));
    tbl[18] = mk(0, 1, 0, 1, 0, 0, 0, 10'd0, 16'h0000, ex(0,0,0,0,0,16'd1,0));
    tbl[19] = mk(1, 0, 0, 0, 0, 0, 0, 10'd0, 16'h0000, ex(0,0,0,0,0,16'd1,0));
    tbl[20] = mk(0, 0, 0, 0, 1, 0, 0, 10'd0, 16'h0000, ex(0,0,0,0,0,16'd1,0));
    tbl[21] = mk(0, 0, 0, 0, 1, 0, 0, 10'd0, 16'h0000, ex(1,1,0,0,1,16'd1,0));
    tbl[22] = mk(0, 0, 0, 0, 1, 0, 0, 10'd0, 16'h0000, ex(1,0,1,1,1,16'd1,0));
    tbl[23] = mk(0, 0, 0, 0, 0, 0, 0, 10'd0, 16'h0000, ex(1,0,1,1,1,16'd1,0));
    tbl[24] = mk(0, 0, 1, 0, 1, 0, 0, 10'd0, 16'h0000, ex(0,0,0,0,1,16'd2,0));
    tbl[25] = mk(0, 0, 0, 0, 1, 0, 0, 10'd0, 16'h0000, ex(0,0,0,1,1,16'd2,0));

    repeat (2) @(negedge clk);
    chk("reset_state", {10'h0, obs()}, {10'h0, ex(0,0,0,1,0,16'd0,0)});
    reset_n = 1'b1;

    // Load bank 0 while idle, then read it back.
    @(negedge clk);
    host_write = 1'b1; host_bank = 1'b0; host_addr = 10'd5; host_wdata = 16'h1234;
    #1;
    chk("idle_write_no_wait", {31'h0, host_waitrequest}, 32'h0);
    @(negedge clk);
    host_write = 1'b0;
    fetch_chk("fetch_b0_a5", 10'd5, 16'h1234);

    for (int i = 0; i < 26; i++) begin
      @(negedge clk);
      ctrl_go = tbl[i].go; ctrl_swap = tbl[i].swap; ctrl_halt = tbl[i].halt;
      ctrl_bank = tbl[i].cbank; core_waiting = tbl[i].cw;
      host_write = tbl[i].hw; host_bank = tbl[i].hbank;
      host_addr = tbl[i].haddr; host_wdata = tbl[i].hdata;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d", i), {10'h0, obs()}, {10'h0, tbl[i].exp});
    end
    @(negedge clk);
    ctrl_go = 1'b0; ctrl_swap = 1'b0; ctrl_halt = 1'b0; host_write = 1'b0;

    fetch_chk("fetch_b1_a0", 10'd0, 16'hBEEF);

    run_once();
    chk("count_3", {s_run_count, status_run_count}, {2'd3, 16'd3});
    run_once();
    chk("count_wrap", {s_run_count, status_run_count}, {2'd0, 16'd4});

    // Enter DRAIN with a swap back to bank 0 pending, then reset mid-cycle.
    @(negedge clk); ctrl_go = 1'b1; core_waiting = 1'b1;
    @(negedge clk); ctrl_go = 1'b0;
    @(negedge clk); core_waiting = 1'b0;
    @(negedge clk); ctrl_swap = 1'b1; ctrl_bank = 1'b0;
    @(negedge clk); ctrl_swap = 1'b0;
    @(posedge clk);
    #2;
    chk("drain_pending", {10'h0, obs()}, {10'h0, ex(0,0,0,0,1,16'd4,0)});
    reset_n = 1'b0;
    #1;
    chk("async_reset", {10'h0, obs()}, {10'h0, ex(0,0,0,1,0,16'd0,0)});
    chk("async_reset_w", {27'h0, s_pause_n, s_resume, s_running, s_ready, s_active_bank},
        {27'h0, 5'b00010});
    @(negedge clk);
    core_waiting = 1'b1;
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("after_reset_idle", {10'h0, obs()}, {10'h0, ex(0,0,0,1,0,16'd0,0)});

    fetch_chk("fetch_b0_a7", 10'd7, 16'h5A5A);
    fetch_chk("fetch_b0_a5_kept", 10'd5, 16'h1234);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
